cpu4_wbck: RTL

CPU4_WBCK -- requirements
Module: cpu4_wbck

---
 rtl/cpu4_wbck_pkg.sv | 14 +
 rtl/cpu4_wbck_dfflr.sv | 14 +
 rtl/cpu4_wbck_fifo.sv | 39 +++
 rtl/cpu4_wbck.sv | 68 ++++++
 4 files changed

// File: rtl/cpu4_wbck_pkg.sv
// cpu4_wbck_pkg: widths, FIFO geometry and writeback entry/grant types
package cpu4_wbck_pkg;
  localparam int XLEN = 32;
  localparam int RFIDX_WIDTH = 5;
  localparam int FIFO_DEPTH = 2;
  localparam int PTR_W = 1;
  localparam int CNT_W = 2;
  localparam logic [1:0] STARV_MAX = 2'd2;
  typedef struct packed {
    logic [RFIDX_WIDTH-1:0] idx;
    logic [XLEN-1:0] data;
  } wb_ent_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_FIFO, GNT_ALU} gnt_t;
endpackage

// File: rtl/cpu4_wbck_dfflr.sv
// cpu4_wbck_dfflr: enable-load flop with synchronous active-high reset to zero
module cpu4_wbck_dfflr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/cpu4_wbck_fifo.sv
// cpu4_wbck_fifo: 2-entry in-order LSU result buffer exposing entry valid/idx for hazard checks
module cpu4_wbck_fifo
  import cpu4_wbck_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   push,
  input  wb_ent_t                                push_ent,
  input  logic                                   pop,
  output wb_ent_t                                head,
  output logic                                   empty,
  output logic                                   full,
  output logic [FIFO_DEPTH-1:0]                  ent_vld,
  output logic [FIFO_DEPTH-1:0][RFIDX_WIDTH-1:0] ent_idx
);
  wb_ent_t mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= push_ent;
  assign head = mem[rptr];
  assign empty = cnt == '0;
  assign full = cnt == CNT_W'(FIFO_DEPTH);
  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_ent
    // with one entry held only the slot under the read pointer is live
    assign ent_vld[i] = full | (!empty & (rptr == PTR_W'(i)));
    assign ent_idx[i] = mem[i].idx;
  end
endmodule

// File: rtl/cpu4_wbck.sv
// cpu4_wbck: writeback arbiter between buffered LSU results and ALU results,
// with starvation override and a pending-write hazard query
module cpu4_wbck
  import cpu4_wbck_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_wbck_valid,
  output logic                   alu_wbck_ready,
  input  logic [RFIDX_WIDTH-1:0] alu_wbck_idx,
  input  logic [XLEN-1:0]        alu_wbck_data,
  input  logic                   lsu_wbck_valid,
  output logic                   lsu_wbck_ready,
  input  logic [RFIDX_WIDTH-1:0] lsu_wbck_idx,
  input  logic [XLEN-1:0]        lsu_wbck_data,
  output logic                   rd_wen,
  output logic [RFIDX_WIDTH-1:0] rd_idx,
  output logic [XLEN-1:0]        rd_data,
  input  logic [RFIDX_WIDTH-1:0] chk_idx,
  output logic                   chk_hit
);
  wb_ent_t head, gnt_ent;
  logic empty, full, override, wen_d, hit;
  logic [1:0] starv;
  logic [FIFO_DEPTH-1:0] ent_vld;
  logic [FIFO_DEPTH-1:0][RFIDX_WIDTH-1:0] ent_idx;
  gnt_t gnt;
  cpu4_wbck_fifo u_fifo (
    .clk(clk),
    .rst(rst),
    .push(lsu_wbck_valid & lsu_wbck_ready),
    .push_ent({lsu_wbck_idx, lsu_wbck_data}),
    .pop(gnt == GNT_FIFO),
    .head(head),
    .empty(empty),
    .full(full),
    .ent_vld(ent_vld),
    .ent_idx(ent_idx)
  );
  assign override = starv == STARV_MAX;
  assign lsu_wbck_ready = !full;
  assign alu_wbck_ready = empty | override;
  always_comb begin
    gnt = (!empty & !(override & alu_wbck_valid)) ? GNT_FIFO :
          (alu_wbck_valid & alu_wbck_ready) ? GNT_ALU : GNT_NONE;
    gnt_ent = (gnt == GNT_FIFO) ? head : {alu_wbck_idx, alu_wbck_data};
    wen_d = (gnt != GNT_NONE) & (gnt_ent.idx != '0);
  end
  // counts LSU pops that made a waiting ALU result wait
  always_ff @(posedge clk)
    if (rst) starv <= '0;
    else if (gnt == GNT_ALU) starv <= '0;
    else if (gnt == GNT_FIFO & alu_wbck_valid & !override) starv <= starv + 2'd1;
  cpu4_wbck_dfflr #(.W(1)) u_wen (
    .clk(clk), .rst(rst), .en(1'b1), .d(wen_d), .q(rd_wen)
  );
  cpu4_wbck_dfflr #(.W(RFIDX_WIDTH)) u_idx (
    .clk(clk), .rst(rst), .en(gnt != GNT_NONE), .d(gnt_ent.idx), .q(rd_idx)
  );
  cpu4_wbck_dfflr #(.W(XLEN)) u_data (
    .clk(clk), .rst(rst), .en(gnt != GNT_NONE), .d(gnt_ent.data), .q(rd_data)
  );
  always_comb begin
    hit = rd_wen & (rd_idx == chk_idx);
    for (int i = 0; i < FIFO_DEPTH; i++) hit = hit | (ent_vld[i] & (ent_idx[i] == chk_idx));
    chk_hit = (chk_idx != '0) & hit;
  end
endmodule
